// File: rtl/io_map_pkg.sv
// io_map_pkg: CPU IO address map and bus width default shared by the IO decode.
package io_map_pkg;
  localparam int DATA_W_DEFAULT = 16;
  localparam logic [15:0] IO_MEM = 16'hCFFD;
  localparam logic [15:0] SWITCHES_LOC = 16'hCFFD;
  localparam logic [15:0] LEDS_LOC = 16'hCFFE;
  localparam logic [15:0] SW_STATUS_LOC = 16'hCFFF;
endpackage

// File: rtl/switch_io_port_debounce_tick.sv
// debounce_tick: free-running 0..DEBOUNCE_CYCLES-1 counter with a one-cycle tick at the wrap.
module debounce_tick #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1);
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/switch_io_port.sv
// switch_io_port: synchronized, debounced switch input port on the CPU IO read path.
// Define SWITCH_CHANGE_EN to add the sticky change flags, SW_STATUS_LOC and irq.
module switch_io_port
  import io_map_pkg::*;
#(
  parameter int NSW = 10,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSW-1:0]    sw_raw,
  input  logic [DATA_W-1:0] addr,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_hit,
  output logic              irq,
  output logic [NSW-1:0]    sw_stable
);
  logic tick;
  logic [NSW-1:0] meta_q, sync_q, samp_q, samp_d, stable_q, stable_d, agree, st_val;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic rd_hit_q, rd_hit_d, hit_sw, hit_st, unused_ok;

  debounce_tick #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // A bit is accepted only when two consecutive tick samples agree.
  assign agree = ~(sync_q ^ samp_q);
  assign hit_sw = addr == DATA_W'(SWITCHES_LOC);
  assign unused_ok = ^{wr_en, wdata};

  always_comb begin
    samp_d = tick ? sync_q : samp_q;
    stable_d = tick ? (agree & sync_q) | (~agree & stable_q) : stable_q;
    rd_hit_d = rd_en & (hit_sw | hit_st);
    rdata_d = !rd_en ? rdata_q : hit_sw ? DATA_W'(stable_q) : hit_st ? DATA_W'(st_val) : '0;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
      samp_q <= '0;
      stable_q <= '0;
      rdata_q <= '0;
      rd_hit_q <= 1'b0;
    end else begin
      meta_q <= sw_raw;
      sync_q <= meta_q;
      samp_q <= samp_d;
      stable_q <= stable_d;
      rdata_q <= rdata_d;
      rd_hit_q <= rd_hit_d;
    end

`ifdef SWITCH_CHANGE_EN
  logic [NSW-1:0] prev_q, change_q, change_d, clr;
  logic irq_q;
  assign hit_st = addr == DATA_W'(SW_STATUS_LOC);
  assign st_val = change_q;
  assign irq = irq_q;
  // A fresh toggle is OR-ed in after the clear so a coincident set survives.
  assign clr = (wr_en && hit_st) ? wdata[NSW-1:0] : '0;
  assign change_d = (change_q & ~clr) | (stable_q ^ prev_q);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      prev_q <= '0;
      change_q <= '0;
      irq_q <= 1'b0;
    end else begin
      prev_q <= stable_q;
      change_q <= change_d;
      irq_q <= |change_q;
    end
`else
  assign hit_st = 1'b0;
  assign st_val = '0;
  assign irq = 1'b0;
`endif

  assign rdata = rdata_q;
  assign rd_hit = rd_hit_q;
  assign sw_stable = stable_q;
endmodule
